// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg
//   Shared definitions for the serial ADC link: frame geometry, channel
//   count and address width, the position of the first address bit within
//   the frame, and the responder's state encoding.
package adc_spi_pkg;

  localparam int N_CH           = 8;
  localparam int DW             = 12;
  localparam int FRAME_LEN      = 16;
  localparam int ADDR_W         = $clog2(N_CH);
  localparam int ADDR_BIT_FIRST = 3;   // SCLK rise number carrying addr MSB
  localparam int SYNC_STAGES    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRAP  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync
//   Multi-flop synchroniser for one asynchronous input, followed by a
//   previous-vs-current edge detector on the synchronised level.
// Ports:
//   iCLK   local clock
//   iRST   synchronous reset, active low (chain and history load RST_VAL)
//   iD     asynchronous input pin
//   oQ     synchronised level
//   oRISE  one-cycle pulse on a synchronised 0->1 transition
//   oFALL  one-cycle pulse on a synchronised 1->0 transition
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iD,
  output logic oQ,
  output logic oRISE,
  output logic oFALL
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], iD};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign oQ    = r_sync[SYNC_STAGES-1];
  assign oRISE = ~r_prev &  oQ;
  assign oFALL =  r_prev & ~oQ;

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
//   Emulates an 8-channel 12-bit serial ADC. SCLK/CS_n/DIN from the master
//   are oversampled by iCLK. Each frame shifts out FRAME_LEN-DW leading
//   zeros then the selected sample MSB-first; the address received during a
//   frame selects the channel for the following frame. CS_n may be toggled
//   per frame or held low for back-to-back frames.
// Ports:
//   iCLK, iRST    local clock, synchronous active-low reset
//   iSCLK         master serial clock (idles high)
//   iCS_n         master chip select, active low
//   iDIN          master address line
//   iCH_DATA      flat sample bus, channel k at [k*DW +: DW]
//   oDOUT         serial data to master
//   oDOUT_OE      output enable (0 models high-Z)
//   oADDR         channel serialised in the current frame
//   oFRAME_DONE   pulse after the last SCLK rise of a frame
//   oFRAME_ERR    pulse when CS_n rises mid-frame
//   oBUSY         frame in progress
module adc_spi_responder #(
  parameter int N_CH        = adc_spi_pkg::N_CH,
  parameter int DW          = adc_spi_pkg::DW,
  parameter int FRAME_LEN   = adc_spi_pkg::FRAME_LEN,
  parameter int SYNC_STAGES = adc_spi_pkg::SYNC_STAGES
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iSCLK,
  input  logic                      iCS_n,
  input  logic                      iDIN,
  input  logic [N_CH*DW-1:0]        iCH_DATA,
  output logic                      oDOUT,
  output logic                      oDOUT_OE,
  output logic [$clog2(N_CH)-1:0]   oADDR,
  output logic                      oFRAME_DONE,
  output logic                      oFRAME_ERR,
  output logic                      oBUSY
);
  import adc_spi_pkg::*;

  localparam int AW     = $clog2(N_CH);
  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_din_q;
  logic [1:0] w_unused_din_edges;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .iCLK(iCLK), .iRST(iRST), .iD(iSCLK),
    .oQ(w_sclk_q), .oRISE(w_sclk_rise), .oFALL(w_sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .iCLK(iCLK), .iRST(iRST), .iD(iCS_n),
    .oQ(w_cs_q), .oRISE(w_cs_rise), .oFALL(w_cs_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .iCLK(iCLK), .iRST(iRST), .iD(iDIN),
    .oQ(w_din_q), .oRISE(w_unused_din_edges[0]), .oFALL(w_unused_din_edges[1])
  );

  state_t                 r_state;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [CNT_W-1:0]       r_cnt;
  logic [AW-1:0]          r_new_addr;
  logic [AW-1:0]          r_pend_addr;
  logic [WARM_W-1:0]      r_warm;
  logic                   r_armed;

  logic [DW-1:0]          w_ch [N_CH];
  logic [FRAME_LEN-1:0]   w_load;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_start;
  logic                   w_stop;
  logic                   w_addr_win;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_ch[k] = iCH_DATA[k*DW +: DW];
    end
  end

  always_comb begin
    w_load     = {{(FRAME_LEN-DW){1'b0}}, w_ch[r_pend_addr]};
    w_cnt_nxt  = r_cnt + CNT_W'(1);
    w_addr_win = (w_cnt_nxt >= CNT_W'(ADDR_BIT_FIRST)) &&
                 (w_cnt_nxt <  CNT_W'(ADDR_BIT_FIRST + AW));
    // A new frame starts on a CS_n fall from idle (only once the CS_n
    // synchroniser has been seen high after reset, so a CS_n already low
    // at reset release is not a fall), or on the SCLK fall that follows a
    // completed frame while CS_n stays low.
    w_start = ((r_state == ST_IDLE) && r_armed && w_cs_fall) ||
              ((r_state == ST_WRAP) && !w_cs_rise && w_sclk_fall);
    w_stop  = (r_state != ST_IDLE) && w_cs_rise;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_new_addr  <= '0;
      r_pend_addr <= '0;
      r_warm      <= '0;
      r_armed     <= 1'b0;
      oDOUT       <= 1'b0;
      oDOUT_OE    <= 1'b0;
      oADDR       <= '0;
      oFRAME_DONE <= 1'b0;
      oFRAME_ERR  <= 1'b0;
      oBUSY       <= 1'b0;
    end else begin
      oFRAME_DONE <= 1'b0;
      oFRAME_ERR  <= 1'b0;

      // Wait until the CS_n chain reflects the pin before arming.
      if (r_warm != WARM_W'(SYNC_STAGES)) begin
        r_warm <= r_warm + WARM_W'(1);
      end else if (w_cs_q) begin
        r_armed <= 1'b1;
      end

      if (w_start) begin
        r_shift  <= w_load;
        oDOUT    <= w_load[FRAME_LEN-1];
        oADDR    <= r_pend_addr;
        r_cnt    <= '0;
        oDOUT_OE <= 1'b1;
        oBUSY    <= 1'b1;
        r_state  <= ST_SHIFT;
      end else if (w_stop) begin
        oFRAME_ERR <= (r_state == ST_SHIFT);
        oDOUT      <= 1'b0;
        oDOUT_OE   <= 1'b0;
        oBUSY      <= 1'b0;
        r_state    <= ST_IDLE;
      end else if (r_state == ST_SHIFT) begin
        if (w_sclk_rise) begin
          r_cnt <= w_cnt_nxt;
          // Address arrives MSB first on consecutive rises.
          if (w_addr_win) begin
            r_new_addr <= {r_new_addr[AW-2:0], w_din_q};
          end
          if (w_cnt_nxt == CNT_W'(FRAME_LEN)) begin
            oFRAME_DONE <= 1'b1;
            r_pend_addr <= r_new_addr;
            r_state     <= ST_WRAP;
          end
        end else if (w_sclk_fall && (r_cnt != '0)) begin
          // The fall before rise 1 keeps the first leading zero in place.
          r_shift <= {r_shift[FRAME_LEN-2:0], 1'b0};
          oDOUT   <= r_shift[FRAME_LEN-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;
  import adc_spi_pkg::*;

  localparam int HALF = 4;   // iCLK cycles per SCLK half period

  logic                 iCLK = 1'b0;
  logic                 iRST = 1'b0;
  logic                 iSCLK = 1'b1;
  logic                 iCS_n = 1'b1;
  logic                 iDIN = 1'b0;
  logic [N_CH*DW-1:0]   iCH_DATA = '0;
  logic                 oDOUT, oDOUT_OE, oFRAME_DONE, oFRAME_ERR, oBUSY;
  logic [ADDR_W-1:0]    oADDR;

  adc_spi_responder dut (
    .iCLK(iCLK), .iRST(iRST), .iSCLK(iSCLK), .iCS_n(iCS_n), .iDIN(iDIN),
    .iCH_DATA(iCH_DATA), .oDOUT(oDOUT), .oDOUT_OE(oDOUT_OE), .oADDR(oADDR),
    .oFRAME_DONE(oFRAME_DONE), .oFRAME_ERR(oFRAME_ERR), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [15:0] word;
    logic [2:0]  addr;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] ch_mem [N_CH];
  logic [2:0]  m_pend = 3'd0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_err = 0;
  int          obs_err = 0;
  logic [15:0] cap = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    ch_mem[k] = v;
    iCH_DATA[k*DW +: DW] = v;
  endtask

  // Master behaviour: each rise is preceded by a fall; DIN changes on falls.
  task automatic run_frame(input logic [2:0] a, input int nrise, input bit do_fall,
                           input bit do_release, input int chg_at, input logic [11:0] chg_val);
    exp_t e;
    if (nrise == FRAME_LEN) begin
      e.word = {4'b0000, ch_mem[m_pend]};
      e.addr = m_pend;
      sb_q.push_back(e);
    end
    if (do_fall) begin
      iCS_n = 1'b0;
      wait_clk(HALF);
    end
    for (int r = 1; r <= nrise; r++) begin
      iSCLK = 1'b0;
      iDIN  = (r >= 3 && r <= 5) ? a[5-r] : 1'($urandom);
      if (r == chg_at) set_ch(int'(m_pend), chg_val);
      wait_clk(HALF);
      iSCLK = 1'b1;
      wait_clk(HALF);
    end
    if (nrise == FRAME_LEN) m_pend = a;
    if (do_release) begin
      iCS_n = 1'b1;
      wait_clk(2*HALF);
    end
  endtask

  // Master samples DOUT on SCLK rise while selected.
  always @(posedge iSCLK) begin
    if (!iCS_n) cap <= {cap[14:0], oDOUT};
  end

  // Scoreboard monitor.
  always @(negedge iCLK) begin
    exp_t e;
    if (oFRAME_DONE) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_unexpected: got frame_done with word %0h, expected none", cap);
      end else begin
        e = sb_q.pop_front();
        check("frame_word", {16'h0, cap}, {16'h0, e.word});
        check("frame_addr", {29'h0, oADDR}, {29'h0, e.addr});
        check("oe_busy_at_done", {30'h0, oDOUT_OE, oBUSY}, 32'h3);
      end
    end
    if (oFRAME_ERR) obs_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit cs_low;
    bit rel;
    logic [2:0] a;

    for (int k = 0; k < N_CH; k++) set_ch(k, 12'($urandom));
    wait_clk(5);
    check("reset_outputs", {24'h0, oDOUT, oDOUT_OE, oADDR, oFRAME_DONE, oFRAME_ERR, oBUSY}, 32'h0);
    iRST = 1'b1;
    wait_clk(10);

    // Single frames
    set_ch(0, 12'hA5C);
    set_ch(3, 12'h0F1);
    run_frame(3'd3, 16, 1, 1, 0, 12'h0);
    run_frame(3'd5, 16, 1, 1, 0, 12'h0);

    // Continuous frames with CS_n held low
    set_ch(5, 12'h135); set_ch(7, 12'hBEE); set_ch(1, 12'h7C4); set_ch(2, 12'h9A0);
    run_frame(3'd7, 16, 1, 0, 0, 12'h0);
    run_frame(3'd1, 16, 0, 0, 0, 12'h0);
    run_frame(3'd2, 16, 0, 0, 0, 12'h0);
    run_frame(3'd4, 16, 0, 1, 0, 12'h0);

    // Aborted frame: CS_n rises after 9 rises
    run_frame(3'd6, 9, 1, 0, 0, 12'h0);
    iCS_n = 1'b1;
    exp_err++;
    wait_clk(6);
    check("err_pulse_count", obs_err, exp_err);
    check("idle_after_err", {29'h0, oDOUT, oDOUT_OE, oBUSY}, 32'h0);
    run_frame(3'd0, 16, 1, 1, 0, 12'h0);   // still returns channel 4

    // Sample snapshot: active channel data changes mid-frame
    set_ch(0, 12'hFFF);
    run_frame(3'd6, 16, 1, 1, 6, 12'h000);

    // Reset mid-frame with CS_n held low through release
    run_frame(3'd2, 7, 1, 0, 0, 12'h0);
    iRST = 1'b0;
    wait_clk(1);
    check("reset_midframe", {24'h0, oDOUT, oDOUT_OE, oADDR, oFRAME_DONE, oFRAME_ERR, oBUSY}, 32'h0);
    wait_clk(2);
    iRST = 1'b1;
    wait_clk(12);
    check("no_start_cs_low_at_release", {30'h0, oDOUT_OE, oBUSY}, 32'h0);
    iCS_n = 1'b1;
    wait_clk(8);
    m_pend = 3'd0;
    set_ch(0, 12'h3D2);
    run_frame(3'd1, 16, 1, 1, 0, 12'h0);

    // Randomised mix of single and continuous frames
    cs_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a   = 3'($urandom_range(0, 7));
      rel = (i == 11) ? 1'b1 : 1'($urandom_range(0, 1));
      set_ch($urandom_range(0, N_CH-1), 12'($urandom));
      run_frame(a, 16, !cs_low, rel, 0, 12'h0);
      cs_low = !rel;
    end

    wait_clk(10);
    check("scoreboard_drained", sb_q.size(), 0);
    check("err_total", obs_err, exp_err);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
